ctrl_pipe_chain: RTL

- Parametrised control-signal pipeline that carries decoded control words from ID through STAGES pipeline registers.
- Each stage has a valid bit, a hazard-unit hold, a flush, and automatic bubble insertion below a held stage.
- A memory-handshake FSM holds the memory stage (and everything upstream) until the data memory acknowledges a request.
- Successor to the fixed three-register controller chain; the decoders stay outside and feed i_ctrl.

---
 rtl/ctrl_pipe_chain.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ctrl_pipe_chain.sv
// ctrl_pipe_chain: control-word pipeline from ID through STAGES registers.
// Each register carries a payload and a valid bit. The hazard unit can hold
// or flush any register. When a register is held and the one below it is
// not, a bubble is inserted below it.
// A small handshake FSM holds the memory stage, and everything upstream of
// it, until data memory acknowledges the request.
// Handshake: o_memReq is a level request. It is accepted on any cycle where
// i_memReady is high. While the request is not yet accepted, the memory
// stage and all stages above it hold. After an accepted request is parked
// by some other hold, the FSM sits in ACK so that the request is not issued
// a second time.
module ctrl_pipe_chain #(
  parameter int STAGES     = 3,
  parameter int WIDTH      = 20,
  parameter int MEM_STAGE  = 1,
  parameter int MEMREQ_BIT = 16,
  parameter int CNT_W      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        i_ctrl,
  input  logic                    i_valid,
  input  logic [STAGES-1:0]       i_stall,
  input  logic [STAGES-1:0]       i_flush,
  input  logic                    i_memReady,
  output logic [STAGES*WIDTH-1:0] o_ctrl,
  output logic [STAGES-1:0]       o_valid,
  output logic                    o_memReq,
  output logic                    o_stallUp,
  output logic [CNT_W-1:0]        o_memWaitCnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic [WIDTH-1:0]  r_ctrl [STAGES];
  logic [STAGES-1:0] r_valid;

  logic [STAGES:0]   w_hold;
  logic [STAGES-1:0] w_bubble;
  logic [WIDTH-1:0]  w_up_ctrl [STAGES];
  logic [STAGES-1:0] w_up_valid;
  logic              w_mem_req;
  logic              w_mem_wait;

  // Request strobe (FSM output): comes only from registers, and is masked
  // while an accepted request is parked in ACK.
  always_comb begin
    w_mem_req = r_valid[MEM_STAGE] & r_ctrl[MEM_STAGE][MEMREQ_BIT] &
                (r_state != ST_ACK);
  end

  assign w_mem_wait = w_mem_req & ~i_memReady;

  // Hold chain: a hold at any register also freezes every register above it.
  always_comb begin
    w_hold = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_hold[k] = i_stall[k] | ((k == MEM_STAGE) & w_mem_wait) | w_hold[k+1];
    end
  end

  // Upstream source for each register. A register gets a bubble when the
  // register above it is held. Reg 0 takes i_ctrl, with the payload zeroed
  // when i_valid is low.
  always_comb begin
    w_bubble      = '0;
    w_up_ctrl[0]  = i_valid ? i_ctrl : '0;
    w_up_valid    = '0;
    w_up_valid[0] = i_valid;
    for (int k = 1; k < STAGES; k++) begin
      w_bubble[k]   = w_hold[k-1];
      w_up_ctrl[k]  = r_ctrl[k-1];
      w_up_valid[k] = r_valid[k-1];
    end
  end

  // Pipeline registers: flush beats hold, hold beats bubble, bubble beats load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        r_ctrl[k] <= '0;
      end
      r_valid <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (i_flush[k]) begin
          r_ctrl[k]  <= '0;
          r_valid[k] <= 1'b0;
        end else if (w_hold[k]) begin
          r_ctrl[k]  <= r_ctrl[k];
          r_valid[k] <= r_valid[k];
        end else if (w_bubble[k]) begin
          r_ctrl[k]  <= '0;
          r_valid[k] <= 1'b0;
        end else begin
          r_ctrl[k]  <= w_up_ctrl[k];
          r_valid[k] <= w_up_valid[k];
        end
      end
    end
  end

  // FSM state register and the wait-cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // FSM next state. The counter restarts on each new request and saturates.
  // A flush of the memory stage drops the request and keeps the counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_mem_req) begin
          if (!i_memReady) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = CNT_W'(1);
          end else begin
            w_cnt_nxt = '0;
            if (w_hold[MEM_STAGE]) w_state_nxt = ST_ACK;
          end
        end
      end
      ST_WAIT: begin
        if (!i_memReady) begin
          if (r_cnt != '1) w_cnt_nxt = r_cnt + CNT_W'(1);
        end else if (w_hold[MEM_STAGE]) begin
          w_state_nxt = ST_ACK;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (!w_hold[MEM_STAGE]) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (i_flush[MEM_STAGE]) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = r_cnt;
    end
  end

  // Output mapping: pack the register payloads into the output bus and
  // drive the status outputs.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      o_ctrl[k*WIDTH +: WIDTH] = r_ctrl[k];
    end
    o_valid      = r_valid;
    o_memReq     = w_mem_req;
    o_stallUp    = w_hold[0];
    o_memWaitCnt = r_cnt;
  end

endmodule
